// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending FSM (IDLE / VEND / PAYOUT) with registered outputs.
// Optional refund path enabled by defining VM_REFUND_EN (adds the cancel port).
module vending_machine_param #(
   parameter int PRICE_UNITS = 3,
   parameter int CREDIT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                five_coin,
   input  logic                ten_coin,
`ifdef VM_REFUND_EN
   input  logic                cancel,
`endif
   output logic                bottle,
   output logic                change,
   output logic                coin_reject,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      PAYOUT = 2'd2
   } state_t;

   // One extra bit so credit + 2 can never wrap before the price compare.
   localparam logic [CREDIT_W:0] PRICE = (CREDIT_W+1)'(PRICE_UNITS);
   localparam logic [CREDIT_W:0] ONE   = (CREDIT_W+1)'(1);
   localparam logic [CREDIT_W:0] TWO   = (CREDIT_W+1)'(2);

   state_t              state_reg, state_next;
   logic [CREDIT_W-1:0] credit_reg, credit_next;
   logic [CREDIT_W-1:0] owed_reg, owed_next;
   logic                bottle_reg, bottle_next;
   logic                change_reg, change_next;
   logic                reject_reg, reject_next;
   logic                busy_reg, busy_next;

   logic                any_coin;
   logic                both_coins;
   logic                refund_req;
   logic [CREDIT_W:0]   sum;

   assign any_coin   = five_coin | ten_coin;
   assign both_coins = five_coin & ten_coin;
   assign sum        = {1'b0, credit_reg} + (ten_coin ? TWO : ONE);

`ifdef VM_REFUND_EN
   assign refund_req = cancel && (credit_reg != '0);
`else
   assign refund_req = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         credit_reg <= '0;
         owed_reg   <= '0;
         bottle_reg <= 1'b0;
         change_reg <= 1'b0;
         reject_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         credit_reg <= credit_next;
         owed_reg   <= owed_next;
         bottle_reg <= bottle_next;
         change_reg <= change_next;
         reject_reg <= reject_next;
         busy_reg   <= busy_next;
      end
   end

   // Next-state and credit/owed bookkeeping
   always_comb begin
      state_next  = state_reg;
      credit_next = credit_reg;
      owed_next   = owed_reg;
      case (state_reg)
         IDLE: begin
            if (refund_req) begin
               owed_next   = credit_reg;
               credit_next = '0;
               state_next  = PAYOUT;
            end else if (any_coin && !both_coins) begin
               if (sum >= PRICE) begin
                  owed_next   = CREDIT_W'(sum - PRICE);
                  credit_next = '0;
                  state_next  = VEND;
               end else begin
                  credit_next = CREDIT_W'(sum);
               end
            end
         end
         VEND: begin
            state_next = (owed_reg != '0) ? PAYOUT : IDLE;
         end
         PAYOUT: begin
            // Leave on the cycle the last coin is paid; the zero guard keeps owed from wrapping.
            if (owed_reg <= CREDIT_W'(1)) begin
               owed_next  = '0;
               state_next = IDLE;
            end else begin
               owed_next = owed_reg - CREDIT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output values for the next cycle, derived from the state being entered
   always_comb begin
      bottle_next = (state_next == VEND);
      change_next = (state_next == PAYOUT);
      busy_next   = (state_next != IDLE);
      reject_next = 1'b0;
      if (state_reg != IDLE) begin
         reject_next = any_coin;
      end else if (refund_req || both_coins) begin
         reject_next = any_coin;
      end
   end

   assign bottle      = bottle_reg;
   assign change      = change_reg;
   assign coin_reject = reject_reg;
   assign busy        = busy_reg;
   assign credit      = credit_reg;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: stimulus queues expected observations,
// a negedge monitor pops one whenever a pulse appears or the stimulus requests a probe.
module tb_vending_machine_param;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         five_coin;
   logic         ten_coin;
`ifdef VM_REFUND_EN
   logic         cancel;
`endif
   logic         bottle;
   logic         change;
   logic         coin_reject;
   logic         busy;
   logic [W-1:0] credit;

   always #5 clk = ~clk;

   vending_machine_param #(
      .PRICE_UNITS(3),
      .CREDIT_W   (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .five_coin  (five_coin),
      .ten_coin   (ten_coin),
`ifdef VM_REFUND_EN
      .cancel     (cancel),
`endif
      .bottle     (bottle),
      .change     (change),
      .coin_reject(coin_reject),
      .busy       (busy),
      .credit     (credit)
   );

   typedef struct packed {
      logic         bot;
      logic         chg;
      logic         rej;
      logic         bsy;
      logic [W-1:0] cr;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];
   int    compared   = 0;
   int    mismatched = 0;
   logic  probe_req  = 1'b0;
   logic  done       = 1'b0;
   logic  done_seen  = 1'b0;

   // Monitor: one line per compared transaction
   always @(negedge clk) begin
      obs_t  act;
      obs_t  exp;
      string nm;
      act = {bottle, change, coin_reject, busy, credit};
      if (bottle || change || coin_reject || probe_req) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_output actual bottle=%0b change=%0b reject=%0b busy=%0b credit=%0d required no output",
                     act.bot, act.chg, act.rej, act.bsy, act.cr);
         end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            if (act !== exp) begin
               mismatched++;
               $display("FAIL %s actual bottle=%0b change=%0b reject=%0b busy=%0b credit=%0d required bottle=%0b change=%0b reject=%0b busy=%0b credit=%0d",
                        nm, act.bot, act.chg, act.rej, act.bsy, act.cr,
                        exp.bot, exp.chg, exp.rej, exp.bsy, exp.cr);
            end else begin
               $display("ok   %s bottle=%0b change=%0b reject=%0b busy=%0b credit=%0d",
                        nm, act.bot, act.chg, act.rej, act.bsy, act.cr);
            end
         end
      end
      if (done && !done_seen) begin
         done_seen = 1'b1;
         compared++;
         if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_outputs actual %0d never seen required 0 pending", exp_q.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      probe_req = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic b, input logic c, input logic r,
                             input logic y, input logic [W-1:0] cr);
      obs_t o;
      o = {b, c, r, y, cr};
      exp_q.push_back(o);
      name_q.push_back(nm);
   endtask

   task automatic probe(input string nm, input logic b, input logic c, input logic r,
                        input logic y, input logic [W-1:0] cr);
      expect_out(nm, b, c, r, y, cr);
      probe_req = 1'b1;
   endtask

   initial begin
      rst = 1'b1; five_coin = 1'b0; ten_coin = 1'b0;
`ifdef VM_REFUND_EN
      cancel = 1'b0;
`endif
      tick(); tick();
      probe("reset_state", 0, 0, 0, 0, 4'd0);
      rst = 1'b0;
      tick();

      // five, five, five: credit 1, 2, then bottle with no change
      five_coin = 1'b1; tick();
      probe("fff_credit1", 0, 0, 0, 0, 4'd1); tick();
      probe("fff_credit2", 0, 0, 0, 0, 4'd2); tick();
      five_coin = 1'b0;
      expect_out("fff_bottle", 1, 0, 0, 1, 4'd0); tick();
      probe("fff_idle", 0, 0, 0, 0, 4'd0); tick();

      // five then ten: exact price, no change
      five_coin = 1'b1; tick();
      five_coin = 1'b0;
      probe("ft_credit1", 0, 0, 0, 0, 4'd1);
      ten_coin = 1'b1; tick();
      ten_coin = 1'b0;
      expect_out("ft_bottle", 1, 0, 0, 1, 4'd0); tick();
      probe("ft_idle", 0, 0, 0, 0, 4'd0); tick();

      // ten, ten: bottle then one change pulse
      ten_coin = 1'b1; tick();
      probe("tt_credit2", 0, 0, 0, 0, 4'd2); tick();
      ten_coin = 1'b0;
      expect_out("tt_bottle", 1, 0, 0, 1, 4'd0); tick();
      expect_out("tt_change", 0, 1, 0, 1, 4'd0); tick();
      probe("tt_idle", 0, 0, 0, 0, 4'd0); tick();

      // five held through VEND and PAYOUT is rejected, credit untouched
      ten_coin = 1'b1; tick(); tick();
      ten_coin = 1'b0; five_coin = 1'b1;
      expect_out("busy_bottle", 1, 0, 0, 1, 4'd0); tick();
      expect_out("busy_rej_vend", 0, 1, 1, 1, 4'd0); tick();
      expect_out("busy_rej_pay", 0, 0, 1, 0, 4'd0);
      five_coin = 1'b0; tick();
      probe("busy_idle", 0, 0, 0, 0, 4'd0); tick();

      // both coins at once: rejected, credit held
      five_coin = 1'b1; tick();
      probe("both_credit1", 0, 0, 0, 0, 4'd1);
      ten_coin = 1'b1; tick();
      expect_out("both_reject", 0, 0, 1, 0, 4'd1);
      five_coin = 1'b0; tick();
      ten_coin = 1'b0;
      expect_out("both_bottle", 1, 0, 0, 1, 4'd0); tick();
      probe("both_idle", 0, 0, 0, 0, 4'd0); tick();

      // reset during VEND with a coin present: pending change discarded, no reject
      ten_coin = 1'b1; tick(); tick();
      ten_coin = 1'b0;
      expect_out("rv_bottle", 1, 0, 0, 1, 4'd0);
      rst = 1'b1; five_coin = 1'b1; tick();
      probe("rv_reset", 0, 0, 0, 0, 4'd0);
      rst = 1'b0; five_coin = 1'b0; tick(); tick();
      probe("rv_idle", 0, 0, 0, 0, 4'd0); tick();

      // reset during the change cycle
      ten_coin = 1'b1; tick(); tick();
      ten_coin = 1'b0;
      expect_out("rc_bottle", 1, 0, 0, 1, 4'd0); tick();
      expect_out("rc_change", 0, 1, 0, 1, 4'd0);
      rst = 1'b1; tick();
      probe("rc_reset", 0, 0, 0, 0, 4'd0);
      rst = 1'b0; tick();
      probe("rc_idle", 0, 0, 0, 0, 4'd0); tick();

      // reset clears accumulated credit even with a coin offered
      five_coin = 1'b1; tick();
      probe("rcr_credit1", 0, 0, 0, 0, 4'd1);
      rst = 1'b1; tick();
      five_coin = 1'b0;
      probe("rcr_reset", 0, 0, 0, 0, 4'd0);
      rst = 1'b0; tick();

`ifdef VM_REFUND_EN
      // ten then cancel (with a coin): two change pulses, no bottle
      ten_coin = 1'b1; tick();
      ten_coin = 1'b0;
      probe("rf_credit2", 0, 0, 0, 0, 4'd2);
      cancel = 1'b1; five_coin = 1'b1; tick();
      cancel = 1'b0; five_coin = 1'b0;
      expect_out("rf_change1", 0, 1, 1, 1, 4'd0); tick();
      expect_out("rf_change2", 0, 1, 0, 1, 4'd0); tick(); tick();
      probe("rf_idle", 0, 0, 0, 0, 4'd0); tick();
      // cancel with zero credit is ignored
      cancel = 1'b1; tick();
      cancel = 1'b0;
      probe("rf_zero_ignored", 0, 0, 0, 0, 4'd0); tick();
`endif

      tick();
      done = 1'b1;
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
